vec_wb_arbiter: RTL



---
 rtl/gpu_vec_pkg.sv | 18 +
 rtl/vec_wb_fifo.sv | 40 ++++
 rtl/vec_wb_arbiter.sv | 97 +++++++++
 3 files changed

// File: rtl/gpu_vec_pkg.sv
// gpu_vec_pkg: shared vector-pipeline constants and types for the writeback stage.
package gpu_vec_pkg;
    localparam int VREG_AW    = 5;
    localparam int NUM_VREGS  = 32;
    localparam int NUM_WB_SRC = 3;
    localparam int VEC_DATA_W = 128;

    typedef enum logic [1:0] {WB_VALU = 2'd0, WB_VLSU = 2'd1, WB_VTEX = 2'd2} wb_src_e;

    typedef struct packed {
        logic [VREG_AW-1:0]    rd;
        logic [VEC_DATA_W-1:0] data;
    } wb_entry_t;

    function automatic wb_src_e wb_next(input wb_src_e s);
        return s == WB_VTEX ? WB_VALU : wb_src_e'(s + 2'd1);
    endfunction
endpackage

// File: rtl/vec_wb_fifo.sv
// vec_wb_fifo: small synchronous FIFO buffering one producer's writeback results.
module vec_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic [AW:0]      cnt;

    assign full  = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign head  = mem[rp];

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/vec_wb_arbiter.sv
// vec_wb_arbiter: round-robin two-port writeback arbiter for VALU/VLSU/VTEX results.
// Defining VEC_WB_FWD_EN adds fwd_* bypass outputs driven from the current-cycle grants.
module vec_wb_arbiter import gpu_vec_pkg::*; #(
    parameter int DATA_W     = 128,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_WB_SRC-1:0]                 src_valid,
    output logic [NUM_WB_SRC-1:0]                 src_ready,
    input  logic [NUM_WB_SRC-1:0][VREG_AW-1:0]    src_rd,
    input  logic [NUM_WB_SRC-1:0][DATA_W-1:0]     src_data,
    output logic                                  we0,
    output logic [VREG_AW-1:0]                    waddr0,
    output logic [DATA_W-1:0]                     wdata0,
    output logic                                  we1,
    output logic [VREG_AW-1:0]                    waddr1,
    output logic [DATA_W-1:0]                     wdata1,
    output logic [NUM_VREGS-1:0]                  retire_mask,
    output logic                                  idle
`ifdef VEC_WB_FWD_EN
    ,
    output logic [1:0]                            fwd_valid,
    output logic [1:0][VREG_AW-1:0]               fwd_addr,
    output logic [1:0][DATA_W-1:0]                fwd_data
`endif
);
    localparam int EW = VREG_AW + DATA_W;

    logic [NUM_WB_SRC-1:0] full, empty, pop;
    logic [EW-1:0]         head [NUM_WB_SRC];
    wb_src_e               rr, s, g0_s, g1_s;
    logic                  g0_v, g1_v;

    assign src_ready = rst ? '0 : ~full;

    genvar i;
    for (i = 0; i < NUM_WB_SRC; i++) begin : g_fifo
        vec_wb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (src_valid[i] & src_ready[i]),
            .pop   (pop[i]),
            .din   ({src_rd[i], src_data[i]}),
            .full  (full[i]),
            .empty (empty[i]),
            .head  (head[i])
        );
        assign pop[i] = (g0_v && g0_s == wb_src_e'(2'(i))) || (g1_v && g1_s == wb_src_e'(2'(i)));
    end

    // Port 1 skips any head aimed at port 0's register so the regfile never sees a double write.
    always_comb begin
        g0_v = 1'b0;
        g1_v = 1'b0;
        g0_s = WB_VALU;
        g1_s = WB_VALU;
        s    = rr;
        for (int k = 0; k < NUM_WB_SRC; k++) begin
            if (!empty[s]) begin
                if (!g0_v) begin
                    g0_v = 1'b1;
                    g0_s = s;
                end else if (!g1_v && head[s][EW-1 -: VREG_AW] != head[g0_s][EW-1 -: VREG_AW]) begin
                    g1_v = 1'b1;
                    g1_s = s;
                end
            end
            s = wb_next(s);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr               <= WB_VALU;
            we0              <= 1'b0;
            we1              <= 1'b0;
            {waddr0, wdata0} <= '0;
            {waddr1, wdata1} <= '0;
        end else begin
            if (g0_v) rr <= wb_next(g0_s);
            we0              <= g0_v;
            we1              <= g1_v;
            {waddr0, wdata0} <= g0_v ? head[g0_s] : '0;
            {waddr1, wdata1} <= g1_v ? head[g1_s] : '0;
        end
    end

    assign retire_mask = (we0 ? NUM_VREGS'(1) << waddr0 : '0) | (we1 ? NUM_VREGS'(1) << waddr1 : '0);
    assign idle        = &empty & ~we0 & ~we1;

`ifdef VEC_WB_FWD_EN
    assign fwd_valid                 = {g1_v, g0_v};
    assign {fwd_addr[0], fwd_data[0]} = g0_v ? head[g0_s] : '0;
    assign {fwd_addr[1], fwd_data[1]} = g1_v ? head[g1_s] : '0;
`endif
endmodule
